// File: rtl/chacha_pkg.sv
// Shared ChaCha constants, FSM state type and quarter-round index tables.
package chacha_pkg;

    localparam logic [31:0] CHACHA_SIGMA [0:3] = '{
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574
    };

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ROUND, ST_OUT} chacha_st_t;

    localparam int COL_IDX [0:3][0:3] = '{
        '{0, 4,  8, 12}, '{1, 5,  9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15}
    };

    localparam int DIAG_IDX [0:3][0:3] = '{
        '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7,  8, 13}, '{3, 4,  9, 14}
    };

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter round on one (a, b, c, d) word group.
module chacha_qr
    import chacha_pkg::*;
(
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] c_in,
    input  logic [31:0] d_in,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [31:0] c_out,
    output logic [31:0] d_out
);
    logic [31:0] a1, b1, c1, d1;

    assign a1    = a_in + b_in;
    assign d1    = rotl32(d_in ^ a1, 16);
    assign c1    = c_in + d1;
    assign b1    = rotl32(b_in ^ c1, 12);
    assign a_out = a1 + b1;
    assign d_out = rotl32(d1 ^ a_out, 8);
    assign c_out = c1 + d_out;
    assign b_out = rotl32(b1 ^ c_out, 7);

endmodule

// File: rtl/chacha_stream_core.sv
// ChaCha keystream engine: command in, num_blocks 512-bit blocks out over valid/ready.
// Optional CHACHA_XOR_EN adds a din port and XORs it into ks_data.
module chacha_stream_core
    import chacha_pkg::*;
#(
    parameter int ROUNDS   = 20,
    parameter int QR_LANES = 4,
    parameter int BLK_W    = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [255:0]     key,
    input  logic [95:0]      nonce,
    input  logic [31:0]      ctr_init,
    input  logic [BLK_W-1:0] num_blocks,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic [511:0]     ks_data,
    output logic             ks_last,
    output logic             busy,
    output logic             ctr_wrap
`ifdef CHACHA_XOR_EN
    ,
    input  logic [511:0]     din
`endif
);
    localparam int HR_CYC   = 4 / QR_LANES;
    localparam int N_STEPS  = ROUNDS * HR_CYC;
    localparam int STEP_W   = $clog2(N_STEPS);

    if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
        $error("chacha_stream_core: ROUNDS must be 8, 12 or 20");
    end
    if (!(QR_LANES == 1 || QR_LANES == 2 || QR_LANES == 4)) begin : g_bad_lanes
        $error("chacha_stream_core: QR_LANES must be 1, 2 or 4");
    end

    chacha_st_t         state_reg;
    logic [31:0]        s_reg    [16];
    logic [31:0]        init_reg [16];
    logic [31:0]        s_next   [16];
    logic [STEP_W-1:0]  step_reg;
    logic [BLK_W-1:0]   blocks_left_reg;
    logic [511:0]       ks_reg;
    logic [511:0]       ks_sum;
    logic               ks_valid_reg, ks_last_reg, cmd_ready_reg, busy_reg, ctr_wrap_reg;

    logic [3:0]         lane_idx [QR_LANES][4];
    logic [31:0]        lane_in  [QR_LANES][4];
    logic [31:0]        lane_out [QR_LANES][4];

    // Select which word groups the lanes work on for the current step.
    always_comb begin
        int  grp_base;
        logic half_odd;
        grp_base = (int'(step_reg) % HR_CYC) * QR_LANES;
        half_odd = ((int'(step_reg) / HR_CYC) % 2) != 0;
        for (int l = 0; l < QR_LANES; l++) begin
            for (int k = 0; k < 4; k++) begin
                lane_idx[l][k] = half_odd ? 4'(DIAG_IDX[grp_base + l][k])
                                          : 4'(COL_IDX[grp_base + l][k]);
                lane_in[l][k]  = s_reg[lane_idx[l][k]];
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < QR_LANES; gi++) begin : g_qr
        chacha_qr u_qr (
            .a_in  (lane_in[gi][0]),
            .b_in  (lane_in[gi][1]),
            .c_in  (lane_in[gi][2]),
            .d_in  (lane_in[gi][3]),
            .a_out (lane_out[gi][0]),
            .b_out (lane_out[gi][1]),
            .c_out (lane_out[gi][2]),
            .d_out (lane_out[gi][3])
        );
    end

    always_comb begin
        for (int i = 0; i < 16; i++) s_next[i] = s_reg[i];
        for (int l = 0; l < QR_LANES; l++) begin
            for (int k = 0; k < 4; k++) s_next[lane_idx[l][k]] = lane_out[l][k];
        end
    end

    for (gi = 0; gi < 16; gi++) begin : g_sum
        assign ks_sum[511-32*gi -: 32] = s_reg[gi] + init_reg[gi];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= ST_IDLE;
            step_reg        <= '0;
            blocks_left_reg <= '0;
            ks_reg          <= '0;
            ks_valid_reg    <= 1'b0;
            ks_last_reg     <= 1'b0;
            cmd_ready_reg   <= 1'b1;
            busy_reg        <= 1'b0;
            ctr_wrap_reg    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                s_reg[i]    <= '0;
                init_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        for (int i = 0; i < 4; i++) init_reg[i] <= CHACHA_SIGMA[i];
                        for (int i = 0; i < 8; i++) init_reg[4+i] <= key[255-32*i -: 32];
                        init_reg[12]    <= ctr_init;
                        init_reg[13]    <= nonce[95:64];
                        init_reg[14]    <= nonce[63:32];
                        init_reg[15]    <= nonce[31:0];
                        blocks_left_reg <= num_blocks;
                        ctr_wrap_reg    <= 1'b0;
                        if (num_blocks != '0) begin
                            state_reg     <= ST_LOAD;
                            cmd_ready_reg <= 1'b0;
                            busy_reg      <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    for (int i = 0; i < 16; i++) s_reg[i] <= init_reg[i];
                    step_reg  <= '0;
                    state_reg <= ST_ROUND;
                end
                ST_ROUND: begin
                    for (int i = 0; i < 16; i++) s_reg[i] <= s_next[i];
                    if (step_reg == STEP_W'(N_STEPS - 1)) state_reg <= ST_OUT;
                    else                                  step_reg  <= step_reg + 1'b1;
                end
                ST_OUT: begin
                    // First OUT cycle latches the finished block; later cycles wait for accept.
                    if (!ks_valid_reg) begin
                        ks_valid_reg <= 1'b1;
                        ks_reg       <= ks_sum;
                        ks_last_reg  <= (blocks_left_reg == BLK_W'(1)) ||
                                        (init_reg[12] == 32'hFFFF_FFFF);
                    end else if (ks_ready) begin
                        ks_valid_reg <= 1'b0;
                        ks_last_reg  <= 1'b0;
                        if (ks_last_reg) begin
                            state_reg     <= ST_IDLE;
                            cmd_ready_reg <= 1'b1;
                            busy_reg      <= 1'b0;
                            if (blocks_left_reg > BLK_W'(1)) ctr_wrap_reg <= 1'b1;
                        end else begin
                            blocks_left_reg <= blocks_left_reg - 1'b1;
                            init_reg[12]    <= init_reg[12] + 32'd1;
                            state_reg       <= ST_LOAD;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign ks_valid  = ks_valid_reg;
    assign ks_last   = ks_last_reg;
    assign busy      = busy_reg;
    assign ctr_wrap  = ctr_wrap_reg;
`ifdef CHACHA_XOR_EN
    assign ks_data   = ks_reg ^ (ks_valid_reg ? din : 512'd0);
`else
    assign ks_data   = ks_reg;
`endif

endmodule
